// File: rtl/line_mem_responder.sv
// line_mem_responder: line-granular (256-bit) main-memory stand-in.
// Serves one read or write at a time. pmem_resp_o rises a fixed LATENCY
// cycles after the request is first sampled in IDLE. The backing array
// is never cleared by reset.
module line_mem_responder #(
    parameter int s_offset = 5,
    parameter int s_depth  = 6,
    parameter int LATENCY  = 4
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [31:0]  pmem_address_i,
    input  logic         pmem_read_i,
    input  logic         pmem_write_i,
    input  logic [255:0] pmem_wdata_i,
    output logic [255:0] pmem_rdata_o,
    output logic         pmem_resp_o,
    output logic         err_o
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    // IDLE->BUSY takes one edge and BUSY->RESP takes one more, so the
    // counter covers the remaining LATENCY-2 cycles.
    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 2);

    logic [255:0]        mem_q [0:(2**s_depth)-1];

    logic [1:0]          state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [s_depth-1:0]  idx_q, idx_d;
    logic                op_q, op_d;     // 1 = write, 0 = read
    logic [255:0]        rdata_q;
    logic                err_q, err_d;
    logic                load_rdata;
    logic                mem_we;
    logic                req_held;

    // Offset bits and aliasing upper bits play no part in line selection.
    logic unused_addr;
    assign unused_addr = ^{pmem_address_i[31:s_offset+s_depth], pmem_address_i[s_offset-1:0]};

    // Next-state logic for the handshake FSM and its latched request.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        op_d       = op_q;
        load_rdata = 1'b0;
        mem_we     = 1'b0;
        req_held   = op_q ? pmem_write_i : pmem_read_i;
        case (state_q)
            IDLE: begin
                if (pmem_read_i || pmem_write_i) begin
                    idx_d   = pmem_address_i[s_offset+s_depth-1:s_offset];
                    op_d    = pmem_write_i;   // a write wins when both are set
                    cnt_d   = CNT_LOAD;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (!req_held) begin
                    state_d = IDLE;           // initiator withdrew: drop silently
                end else if (cnt_q == 4'd0) begin
                    state_d    = RESP;
                    load_rdata = !op_q;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
                mem_we  = op_q && !rst_i;
            end
            default: state_d = IDLE;
        endcase
        err_d = err_q | (pmem_read_i & pmem_write_i);
    end

    // Control and output registers; async reset aborts any transaction in flight.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            idx_q   <= '0;
            op_q    <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            op_q    <= op_d;
            err_q   <= err_d;
            if (load_rdata) rdata_q <= mem_q[idx_q];
        end
    end

    // Line array: write commits on the edge leaving RESP.
    always_ff @(posedge clk_i) begin
        if (mem_we) mem_q[idx_q] <= pmem_wdata_i;
    end

    assign pmem_resp_o  = (state_q == RESP);
    assign pmem_rdata_o = rdata_q;
    assign err_o        = err_q;
endmodule

// File: tb/tb_line_mem_responder.sv
// Directed bench for line_mem_responder (LATENCY=4, s_offset=5, s_depth=6).
module tb_line_mem_responder;
    localparam int LAT = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [31:0]  addr = '0;
    logic         rd = 1'b0, wr = 1'b0;
    logic [255:0] wdata = '0;
    logic [255:0] rdata;
    logic         resp, err;

    int n_chk = 0;
    int n_pass = 0;

    line_mem_responder #(.s_offset(5), .s_depth(6), .LATENCY(LAT)) dut (
        .clk_i(clk), .rst_i(rst), .pmem_address_i(addr),
        .pmem_read_i(rd), .pmem_write_i(wr), .pmem_wdata_i(wdata),
        .pmem_rdata_o(rdata), .pmem_resp_o(resp), .err_o(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h exp %h", tag, got, exp);
    endtask

    // Request issued in the current cycle (cycle 0); returns the cycle in
    // which resp was seen (99 on timeout), rdata then, and err in cycle 1.
    // Leaves the bench in the IDLE cycle right after resp.
    task automatic txn(input logic r, input logic w, input logic [31:0] a,
                       input logic [255:0] d, output int lat,
                       output logic [255:0] rdat, output logic err1);
        rd = r; wr = w; addr = a; wdata = d;
        lat = 99; rdat = '0; err1 = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            if (k == 1) err1 = err;
            if (resp) begin lat = k; rdat = rdata; break; end
        end
        rd = 1'b0; wr = 1'b0;
        @(posedge clk); #1;
        chk("resp_one_cycle", resp, 1'b0);
    endtask

    task automatic idle_chk(input string tag, input int n);
        logic seen;
        seen = 1'b0;
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
            seen |= resp;
        end
        chk(tag, seen, 1'b0);
    endtask

    initial begin
        int lat;
        logic [255:0] rdat;
        logic e1;
        logic [15:0] mask;
        logic [255:0] A5, L, P, Q, D, R;
        A5 = {32{8'hA5}};
        L  = {8{32'h0123_4567}} ^ {4{64'h0F0F_0000_F0F0_1111}};
        P  = {8{32'h1111_2222}};
        Q  = {8{32'h3333_4444}};
        D  = {4{64'hDEAD_BEEF_CAFE_F00D}};
        R  = {8{32'h5555_6666}};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_resp", resp, 1'b0);
        chk("rst_rdata", rdata, '0);
        chk("rst_err", err, 1'b0);
        rst = 1'b0;
        idle_chk("idle_no_resp", 10);

        // Write A5 to 0x40, then back-to-back reads of the same line
        txn(1'b0, 1'b1, 32'h0000_0040, A5, lat, rdat, e1);
        chk("wr40_lat", lat, LAT);
        txn(1'b1, 1'b0, 32'h0000_0040, '0, lat, rdat, e1);
        chk("rd40_lat", lat, LAT);
        chk("rd40_data", rdat, A5);
        txn(1'b1, 1'b0, 32'h0000_005C, '0, lat, rdat, e1);
        chk("rd5c_data", rdat, A5);
        chk("rdata_held", rdata, A5);

        // Aliasing: 0x2080 maps to the same line index as 0x80
        txn(1'b0, 1'b1, 32'h0000_0080, L, lat, rdat, e1);
        txn(1'b1, 1'b0, 32'h0000_2080, '0, lat, rdat, e1);
        chk("alias_lat", lat, LAT);
        chk("alias_data", rdat, L);

        // Abort: line 3 holds P, a write of Q is withdrawn in BUSY
        txn(1'b0, 1'b1, 32'h0000_0060, P, lat, rdat, e1);
        wr = 1'b1; addr = 32'h0000_0060; wdata = Q;
        repeat (2) begin @(posedge clk); #1; end
        wr = 1'b0;
        idle_chk("abort_no_resp", 8);
        txn(1'b1, 1'b0, 32'h0000_0060, '0, lat, rdat, e1);
        chk("abort_lat", lat, LAT);
        chk("abort_data", rdat, P);

        // Back-to-back: read held from cycle 0 -> resp in cycles 4 and 9
        rd = 1'b1; addr = 32'h0000_0040;
        mask = '0;
        for (int k = 1; k <= 14; k++) begin
            @(posedge clk); #1;
            mask[k] = resp;
            if (k == 9) rd = 1'b0;
        end
        chk("b2b_resp_cycles", mask, 16'h0210);
        chk("b2b_data", rdata, A5);

        // Protocol error: read+write together is a write; err is sticky
        chk("err_before", err, 1'b0);
        txn(1'b1, 1'b1, 32'h0000_00A0, D, lat, rdat, e1);
        chk("err_next_cycle", e1, 1'b1);
        chk("err_wr_lat", lat, LAT);
        chk("err_rdata_untouched", rdata, A5);
        txn(1'b1, 1'b0, 32'h0000_00A0, '0, lat, rdat, e1);
        chk("err_rd_data", rdat, D);
        idle_chk("err_idle", 5);
        chk("err_sticky", err, 1'b1);

        // Async reset mid-BUSY: outputs clear immediately, write never lands
        wr = 1'b1; addr = 32'h0000_00A0; wdata = R;
        repeat (2) begin @(posedge clk); #1; end
        #2 rst = 1'b1;
        #1;
        chk("async_rst_resp", resp, 1'b0);
        chk("async_rst_rdata", rdata, '0);
        chk("async_rst_err", err, 1'b0);
        wr = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        idle_chk("post_rst_no_resp", 10);
        txn(1'b1, 1'b0, 32'h0000_00A0, '0, lat, rdat, e1);
        chk("post_rst_lat", lat, LAT);
        chk("post_rst_data", rdat, D);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
